hack_imem_loader: RTL and testbench



---
 rtl/hack_pkg.sv | 15 +
 rtl/hack_rom_array.sv | 26 ++
 rtl/hack_imem_loader.sv | 133 +++++++++++++
 tb/tb_hack_imem_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack instruction-memory loader slice.
// Widths follow the Hack CPU: 16-bit instructions, 15-bit program counter.
// Loader states walk the big-endian length header, then the data words.
package hack_pkg;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 15;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        RUN
    } ld_state_e;
endpackage

// File: rtl/hack_rom_array.sv
// DEPTH x 16 instruction storage: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge, read is combinational.
// No backpressure; contents are not reset.
module hack_rom_array
    import hack_pkg::*;
#(
    parameter int DEPTH = 32768,
    parameter int AW    = 15
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/hack_imem_loader.sv
// Instruction-fetch responder that loads its memory from a host byte stream, holding the CPU in reset meanwhile.
// Latency: fetch is zero-cycle combinational; cpu_reset falls the cycle after the final byte.
// Backpressure: rx_ready is high in every load state and low in RUN.
module hack_imem_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = 32768
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               load_start,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        word_count
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_PC = (ADDR_W+1)'(DEPTH);
    localparam logic [16:0]     DEPTH_WA = 17'(DEPTH);

    ld_state_e   state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] word_count_q, word_count_d;
    logic        overflow_q, overflow_d;

    logic               accept;
    logic               mem_we;
    logic               addr_in_range;
    logic               pc_in_range;
    logic [INSTR_W-1:0] rd_data;

    // Handshake outputs decode straight from the state register, so they are glitch-free.
    assign cpu_reset  = (state_q != RUN);
    assign busy       = (state_q != RUN);
    assign rx_ready   = (state_q != RUN);
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

    assign accept        = rx_valid && rx_ready;
    assign addr_in_range = ({1'b0, addr_q} < DEPTH_WA);
    assign pc_in_range   = ({1'b0, pc} < DEPTH_PC);
    assign instruction   = (!cpu_reset && pc_in_range) ? rd_data : '0;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        mem_we       = 1'b0;
        case (state_q)
            LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d        = {len_q[15:8], rx_data};
                    addr_d       = '0;
                    word_count_d = '0;
                    state_d      = ({len_q[15:8], rx_data} == 16'd0) ? RUN : DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    // Words past the array are dropped, so word_count tops out at DEPTH.
                    if (addr_in_range) begin
                        mem_we       = 1'b1;
                        word_count_d = word_count_q + 16'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    addr_d  = addr_q + 16'd1;
                    state_d = ((addr_q + 16'd1) == len_q) ? RUN : DATA_HI;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d    = LEN_HI;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            hi_q         <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

    hack_rom_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rom (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q[AW-1:0]),
        .wdata ({hi_q, rx_data}),
        .raddr (pc[AW-1:0]),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_hack_imem_loader.sv
// Directed bench: full-depth and 4-word loaders share one host stream and fetch address.
module tb_hack_imem_loader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] pc;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_start;

    logic [15:0] b_instr, s_instr;
    logic        b_cpu_reset, s_cpu_reset;
    logic        b_rx_ready, s_rx_ready;
    logic        b_busy, s_busy;
    logic        b_overflow, s_overflow;
    logic [15:0] b_wc, s_wc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hack_imem_loader u_big (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .instruction (b_instr),
        .cpu_reset   (b_cpu_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (b_rx_ready),
        .load_start  (load_start),
        .busy        (b_busy),
        .overflow    (b_overflow),
        .word_count  (b_wc)
    );

    hack_imem_loader #(.ADDR_W(15), .DEPTH(4)) u_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .instruction (s_instr),
        .cpu_reset   (s_cpu_reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (s_rx_ready),
        .load_start  (load_start),
        .busy        (s_busy),
        .overflow    (s_overflow),
        .word_count  (s_wc)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one byte after `gap` idle cycles; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        check("rx_ready_big", {15'd0, b_rx_ready}, 16'd1);
        check("rx_ready_small", {15'd0, s_rx_ready}, 16'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic fetch(input logic [14:0] a);
        pc = a;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        pc         = '0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        load_start = 1'b0;
        #3;
        check("rst_cpu_reset", {15'd0, b_cpu_reset}, 16'd1);
        check("rst_busy", {15'd0, b_busy}, 16'd1);
        check("rst_rx_ready", {15'd0, b_rx_ready}, 16'd1);
        check("rst_overflow", {15'd0, b_overflow}, 16'd0);
        check("rst_word_count", b_wc, 16'd0);
        check("rst_instruction", b_instr, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic 3-word image, continuous valid.
        send_word(16'h0003, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_byte(8'h00, 0);
        check("basic_cpu_reset_before_last", {15'd0, b_cpu_reset}, 16'd1);
        send_byte(8'h07, 0);
        check("basic_cpu_reset_after_last", {15'd0, b_cpu_reset}, 16'd0);
        check("basic_busy", {15'd0, b_busy}, 16'd0);
        check("basic_rx_ready", {15'd0, b_rx_ready}, 16'd0);
        fetch(15'd0); check("basic_pc0", b_instr, 16'h1234);
        fetch(15'd1); check("basic_pc1", b_instr, 16'hABCD);
        fetch(15'd2); check("basic_pc2", b_instr, 16'h0007);
        check("basic_pc2_small", s_instr, 16'h0007);
        check("basic_word_count", b_wc, 16'd3);
        check("basic_overflow", {15'd0, b_overflow}, 16'd0);

        // Reload request together with a valid byte: the byte must be refused.
        @(negedge clk);
        load_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'hFF;
        @(negedge clk);
        load_start = 1'b0;
        rx_valid   = 1'b0;
        check("reload_cpu_reset", {15'd0, b_cpu_reset}, 16'd1);
        check("reload_busy", {15'd0, b_busy}, 16'd1);
        fetch(15'd0); check("reload_instr_gated", b_instr, 16'h0000);
        send_word(16'h0001, 0);
        send_word(16'hBEEF, 0);
        fetch(15'd0); check("reload_pc0", b_instr, 16'hBEEF);
        fetch(15'd1); check("reload_pc1_kept", b_instr, 16'hABCD);
        check("reload_word_count", b_wc, 16'd1);

        // Same 3-word image with random idle gaps between bytes.
        pulse_load_start();
        send_word(16'h0003, $urandom_range(5, 1));
        send_word(16'h1234, $urandom_range(5, 1));
        send_word(16'hABCD, $urandom_range(5, 1));
        send_byte(8'h00, $urandom_range(5, 1));
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("gap_cpu_reset_held", {15'd0, b_cpu_reset}, 16'd1);
        send_byte(8'h07, $urandom_range(5, 1));
        check("gap_cpu_reset_after_last", {15'd0, b_cpu_reset}, 16'd0);
        fetch(15'd0); check("gap_pc0", b_instr, 16'h1234);
        fetch(15'd1); check("gap_pc1", b_instr, 16'hABCD);
        fetch(15'd2); check("gap_pc2", b_instr, 16'h0007);
        check("gap_word_count", b_wc, 16'd3);

        // Zero-length image.
        pulse_load_start();
        send_byte(8'h00, 0);
        check("zero_cpu_reset_mid", {15'd0, b_cpu_reset}, 16'd1);
        send_byte(8'h00, 0);
        check("zero_cpu_reset_after", {15'd0, b_cpu_reset}, 16'd0);
        check("zero_word_count", b_wc, 16'd0);
        fetch(15'd0); check("zero_pc0_kept", b_instr, 16'h1234);
        fetch(15'd2); check("zero_pc2_kept", b_instr, 16'h0007);

        // Six words into the 4-deep instance; a stray load_start mid-load is ignored.
        pulse_load_start();
        send_word(16'h0006, 0);
        send_word(16'h1111, 0);
        send_byte(8'h22, 0);
        pulse_load_start();
        send_byte(8'h22, 0);
        send_word(16'h3333, 0);
        send_word(16'h4444, 0);
        check("ovf_not_yet", {15'd0, s_overflow}, 16'd0);
        check("ovf_wc_at_depth", s_wc, 16'd4);
        send_word(16'h5555, 0);
        check("ovf_set_small", {15'd0, s_overflow}, 16'd1);
        send_byte(8'h66, 0);
        check("ovf_cpu_reset_before_last", {15'd0, s_cpu_reset}, 16'd1);
        send_byte(8'h66, 0);
        check("ovf_cpu_reset_after_last", {15'd0, s_cpu_reset}, 16'd0);
        check("ovf_small_wc", s_wc, 16'd4);
        check("ovf_big_wc", b_wc, 16'd6);
        check("ovf_big_overflow", {15'd0, b_overflow}, 16'd0);
        fetch(15'd1); check("ovf_small_pc1", s_instr, 16'h2222);
        fetch(15'd3); check("ovf_small_pc3", s_instr, 16'h4444);
        fetch(15'd4);
        check("ovf_small_pc4_zero", s_instr, 16'h0000);
        check("ovf_big_pc4", b_instr, 16'h5555);
        fetch(15'd5); check("ovf_big_pc5", b_instr, 16'h6666);

        // Reset dropped after three data bytes of a 3-word image.
        pulse_load_start();
        check("ovf_cleared_on_reload", {15'd0, s_overflow}, 16'd0);
        send_word(16'h0003, 0);
        send_word(16'hAABB, 0);
        send_byte(8'hCC, 0);
        check("abort_wc_before", b_wc, 16'd1);
        reset_n = 1'b0;
        #1;
        check("abort_cpu_reset", {15'd0, b_cpu_reset}, 16'd1);
        check("abort_wc_reset", b_wc, 16'd0);
        check("abort_rx_ready", {15'd0, b_rx_ready}, 16'd1);
        @(negedge clk);
        reset_n = 1'b1;
        send_word(16'h0000, 0);
        fetch(15'd0); check("abort_word0_kept", b_instr, 16'hAABB);
        fetch(15'd1); check("abort_word1_old", b_instr, 16'h2222);
        pulse_load_start();
        send_word(16'h0002, 0);
        send_word(16'hCAFE, 0);
        send_word(16'hF00D, 0);
        fetch(15'd0); check("fresh_pc0", b_instr, 16'hCAFE);
        fetch(15'd1); check("fresh_pc1", b_instr, 16'hF00D);
        check("fresh_word_count", b_wc, 16'd2);
        check("fresh_cpu_reset", {15'd0, b_cpu_reset}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
